rom_programavel: RTL

Loadable program memory for the course processor, replacing the fixed instruction ROM. It holds `DEPTH` instruction words of `DATA_WIDTH` bits and is written at run time through a sequential load port with an auto-incrementing pointer. Reads go through a registered fetch port with a valid strobe. It sits between the program loader (switches/UART front end) and the processor fetch stage.

---
 rtl/rom_programavel.sv | 106 ++++++++++
 1 files changed

// File: rtl/rom_programavel.sv
// Loadable instruction memory: sequential load port with an auto-incrementing
// pointer, plus a registered one-cycle fetch port that is disabled while loading.
module rom_programavel #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  leitura_pedido,
    input  logic [ADDR_WIDTH-1:0] endereco,
    output logic [DATA_WIDTH-1:0] dado,
    output logic                  dado_valido,
    input  logic                  carga_inicio,
    input  logic                  carga_valido,
    input  logic [DATA_WIDTH-1:0] carga_dado,
    input  logic                  carga_fim,
    output logic                  a_carregar,
    output logic [ADDR_WIDTH:0]   palavras_carregadas,
    output logic                  cheia
);

    typedef enum logic {
        PRONTO = 1'b0,
        CARGA  = 1'b1
    } estado_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ULTIMO  = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH:0]   ponteiro_q, ponteiro_d;
    logic                  cheia_q, cheia_d;
    logic [DATA_WIDTH-1:0] dado_q, dado_d;
    logic                  valido_q, valido_d;
    logic                  wr_en;
    logic                  em_faixa;

    assign em_faixa = ({1'b0, endereco} < DEPTH_W);

    always_comb begin
        estado_d   = estado_q;
        ponteiro_d = ponteiro_q;
        cheia_d    = cheia_q;
        dado_d     = dado_q;
        valido_d   = 1'b0;
        wr_en      = 1'b0;
        if (estado_q == PRONTO) begin
            // A fetch in the same cycle as carga_inicio is still served.
            if (leitura_pedido) begin
                valido_d = 1'b1;
                dado_d   = em_faixa ? mem[endereco] : '0;
            end
            if (carga_inicio) begin
                estado_d   = CARGA;
                ponteiro_d = '0;
                cheia_d    = 1'b0;
            end
        end else begin
            if (carga_inicio) begin
                ponteiro_d = '0;
            end else begin
                if (carga_valido) begin
                    wr_en      = 1'b1;
                    ponteiro_d = ponteiro_q + 1'b1;
                    // Filling the last slot ends the load; no wrap to 0.
                    if (ponteiro_q == ULTIMO) begin
                        cheia_d  = 1'b1;
                        estado_d = PRONTO;
                    end
                end
                if (carga_fim) estado_d = PRONTO;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= PRONTO;
            ponteiro_q <= '0;
            cheia_q    <= 1'b0;
            dado_q     <= '0;
            valido_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            ponteiro_q <= ponteiro_d;
            cheia_q    <= cheia_d;
            dado_q     <= dado_d;
            valido_q   <= valido_d;
        end
    end

    // Storage is deliberately outside reset so a mid-load reset keeps words.
    always_ff @(posedge clock) begin
        if (wr_en) mem[ponteiro_q[ADDR_WIDTH-1:0]] <= carga_dado;
    end

    assign dado                = dado_q;
    assign dado_valido         = valido_q;
    assign a_carregar          = (estado_q == CARGA);
    assign palavras_carregadas = ponteiro_q;
    assign cheia               = cheia_q;

endmodule
